// File: rtl/pe_row_act_feeder.sv
// pe_row_act_feeder: AFIFO transmit side for one PE row.
// Zero-run compresses activations and broadcasts tokens.
module pe_row_act_feeder #(
  parameter int num_pe_col = 16,
  parameter int activation_width = 16,
  parameter int compressed_act_width = activation_width + 1,
  parameter int max_zero_run = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            zc_en,
  input  logic [num_pe_col-1:0]           col_mask,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [activation_width-1:0]     in_act,
  input  logic                            in_last,
  input  logic [num_pe_col-1:0]           afifo_full,
  output logic [num_pe_col-1:0]           afifo_write,
  output logic [compressed_act_width-1:0] compressed_act_out,
  output logic                            busy
);

  localparam int AW = activation_width;
  localparam int CW = (max_zero_run > 1) ? $clog2(max_zero_run) : 1;

  typedef enum logic {RUNACC, PEND} state_t;

  state_t                          state;
  logic                            h_valid;
  logic [compressed_act_width-1:0] h_data;
  logic [CW-1:0]                   cnt;
  logic [AW-1:0]                   p;

  logic          can_emit;
  logic          fire;
  logic          h_load;
  logic          accept;
  logic [CW:0]   cnt_inc;
  logic          run_full;
  logic          act_zero;

  assign can_emit = ~|(afifo_full & col_mask);
  assign fire     = h_valid & can_emit;
  assign h_load   = ~h_valid | fire;
  assign in_ready = h_load & (state != PEND);
  assign accept   = in_valid & in_ready;
  assign act_zero = (in_act == '0);
  assign cnt_inc  = {1'b0, cnt} + (CW+1)'(1);
  assign run_full = (cnt_inc == (CW+1)'(max_zero_run));

  assign afifo_write        = fire ? col_mask : '0;
  assign compressed_act_out = h_data;
  assign busy = h_valid | (cnt != '0) | (state == PEND);

  // Holding register, run counter and pending-literal FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUNACC;
      h_valid <= 1'b0;
      h_data  <= '0;
      cnt     <= '0;
      p       <= '0;
    end else begin
      if (fire) h_valid <= 1'b0;
      unique case (state)
        PEND: begin
          if (h_load) begin
            h_data  <= {1'b0, p};
            h_valid <= 1'b1;
            state   <= RUNACC;
          end
        end
        default: begin
          if (accept) begin
            if (!zc_en) begin
              h_data  <= {1'b0, in_act};
              h_valid <= 1'b1;
            end else if (act_zero) begin
              if (run_full || in_last) begin
                h_data  <= {1'b1, AW'(cnt)};
                h_valid <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt_inc[CW-1:0];
              end
            end else if (cnt == '0) begin
              h_data  <= {1'b0, in_act};
              h_valid <= 1'b1;
            end else begin
              h_data  <= {1'b1, AW'(cnt - CW'(1))};
              h_valid <= 1'b1;
              p       <= in_act;
              cnt     <= '0;
              state   <= PEND;
            end
          end
        end
      endcase
    end
  end

endmodule
